serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single full-adder bit cell plus a registered carry.
- Accepts two N-bit operands and a carry-in over a valid/ready handshake.
- Adds one bit per clock, LSB first, then presents the N-bit sum and carry-out over a second valid/ready handshake.
- Low-area datapath stage: consumes operands from an upstream producer and feeds the result to a downstream consumer.

Parameters:
- N, 8, operand and sum width in bits; legal range N >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream asserts when a, b, cin are valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  s/cout hold a completed result.
- out_ready  input  1  downstream accepts result this cycle.
- s  output  N  sum, (a + b + cin) mod 2^N.
- cout  output  1  carry-out of bit N-1.

Behaviour:
- Interface: clk is the only clock; reset is asynchronous and active-high.
- Reset (asynchronous, active-high, takes effect immediately):
  - state = IDLE, in_ready = 1, out_valid = 0, s = 0, cout = 0.
  - Operand shift registers, carry register and bit counter cleared.
- Counter width: $clog2(N+1).
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On edge with in_valid=1: capture a into shift reg ra, b into rb, cin into carry reg c; clear count; go to ADD.
  - in_valid=0: stay in IDLE.
- ADD (in_ready = 0, out_valid = 0). Each edge:
  - Bit cell: p = ra[0]^b_reg[0] (i.e. ra[0]^rb[0]), g = ra[0]&rb[0], sbit = p^c.
  - c <= g | (p & c).
  - ra, rb shift right by 1 (zero fill).
  - Sum shift reg rs shifts right with sbit inserted at MSB.
  - count <= count + 1.
  - On the edge where count == N-1, the final bit is processed: s <= completed sum, cout <= final carry; go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - s and cout held stable while out_ready = 0, for any number of cycles.
  - On edge with out_ready=1: go to IDLE.
  - s and cout retain the last result after leaving DONE, until the next completion or reset.
- Latency and throughput:
  - Operands accepted at edge k; out_valid rises after edge k+N.
  - With out_ready tied high, minimum spacing between accepts is N+2 cycles.
- Operand stability: a, b, cin are sampled only on the accepting edge. Changes at any other time have no effect.
- in_valid while in_ready=0 is ignored; no queuing. Upstream must hold its data until the handshake.
- s never shows partial sums; only rs is partial.
- Arithmetic: {cout, s} == a + b + cin exactly; no saturation. Overflow is visible only via cout.
- N=1: ADD lasts exactly one cycle.
- Reset mid-operation (ADD or DONE): the operation is aborted and discarded, and no out_valid pulse follows. After reset deassertion the block accepts a new operation normally.

Test Plan:
- N=8, a=0x00, b=0x00, cin=0 -> out_valid exactly 8 cycles after the accept edge; s=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> s=0xFF, cout=1.
- a=0x5A, b=0x3C, cin=1 -> s=0x97, cout=0; input buses toggled randomly during ADD -> result unchanged.
- Backpressure: out_ready=0 for 5 cycles after completion -> out_valid stays 1 and s/cout stay stable. in_valid=1 throughout -> in_ready=0, no accept. Raise out_ready -> IDLE next cycle with in_ready=1; the next operation completes correctly.
- Assert reset asynchronously (mid-cycle) during the 4th ADD cycle -> in_ready=1, out_valid=0, s=0x00, cout=0 immediately. Then a=0x10, b=0x20, cin=0 -> s=0x30, cout=0.
- Random/exhaustive (N=4: all 512 combinations) back-to-back ops, out_ready randomized -> every {cout, s} equals a+b+cin, delivered in order, one result per accept.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, one full-adder cell plus registered carry,
// with valid/ready handshakes on operands and result.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  ra_q, ra_d, rb_q, rb_d, rs_q, rs_d, s_q, s_d;
  logic          c_q, c_d, cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          p, g, sbit;
  always_comb begin
    p       = ra_q[0] ^ rb_q[0];
    g       = ra_q[0] & rb_q[0];
    sbit    = p ^ c_q;
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    if (state_q == IDLE && in_valid) begin
      ra_d    = a;
      rb_d    = b;
      c_d     = cin;
      cnt_d   = '0;
      state_d = ADD;
    end else if (state_q == ADD) begin
      c_d       = g | (p & c_q);
      ra_d      = ra_q >> 1;
      rb_d      = rb_q >> 1;
      rs_d      = rs_q >> 1;
      rs_d[N-1] = sbit;
      cnt_d     = cnt_q + CW'(1);
      // s only ever updates with a complete sum, never a partial one
      if (cnt_q == CW'(N - 1)) begin
        s_d     = rs_d;
        cout_d  = c_d;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rs_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign s         = s_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and exhaustive checks of serial_adder at N=8 and N=4
// using a result scoreboard fed at each accept and drained at each delivery.
module tb_serial_adder;
  logic       clk = 1'b0, reset = 1'b1;
  logic       in_valid8 = 1'b0, in_ready8, cin8 = 1'b0, out_valid8, out_ready8 = 1'b1, cout8;
  logic [7:0] a8 = '0, b8 = '0, s8;
  logic       in_valid4 = 1'b0, in_ready4, cin4 = 1'b0, out_valid4, out_ready4 = 1'b1, cout4;
  logic [3:0] a4 = '0, b4 = '0, s4;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  int         n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  serial_adder #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .cout(cout8)
  );
  serial_adder #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .s(s4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboards: push the model sum on each accept, pop and compare on each delivery
  always @(negedge clk) begin
    if (in_valid8 && in_ready8) q8.push_back({1'b0, a8} + {1'b0, b8} + 9'(cin8));
    if (out_valid8 && out_ready8) begin
      chk("res8_pending", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) chk("res8", {23'd0, cout8, s8}, {23'd0, q8.pop_front()});
    end
    if (in_valid4 && in_ready4) q4.push_back({1'b0, a4} + {1'b0, b4} + 5'(cin4));
    if (out_valid4 && out_ready4) begin
      chk("res4_pending", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) chk("res4", {27'd0, cout4, s4}, {27'd0, q4.pop_front()});
    end
  end

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic ci);
    int t;
    in_valid8 = 1'b1; a8 = x; b8 = y; cin8 = ci;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready8) break;
    end
    chk("accept8", 32'(t < 50), 32'd1);
    @(posedge clk); #1 in_valid8 = 1'b0;
  endtask

  task automatic wait_done8(input bit tog, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (tog) begin a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); end
      if (out_valid8) begin cyc = i; break; end
    end
  endtask

  task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    int t;
    in_valid4 = 1'b1; a4 = x; b4 = y; cin4 = ci;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready4) break;
      @(posedge clk); #1 out_ready4 = 1'($urandom_range(0, 1));
    end
    chk("accept4", 32'(t < 200), 32'd1);
    @(posedge clk); #1 in_valid4 = 1'b0; out_ready4 = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int         cyc;
    logic [7:0] s_hold;
    logic       c_hold;
    #2;
    chk("rst_in_ready", 32'(in_ready8), 32'd1);
    chk("rst_out_valid", 32'(out_valid8), 32'd0);
    chk("rst_s", 32'(s8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    send8(8'h00, 8'h00, 1'b0);
    wait_done8(1'b0, cyc);
    chk("lat_zero", 32'(cyc), 32'd8);
    @(posedge clk); #1;
    send8(8'hFF, 8'h01, 1'b0);
    wait_done8(1'b0, cyc);
    chk("ff_01_s", 32'(s8), 32'h00);
    chk("ff_01_cout", 32'(cout8), 32'd1);
    @(posedge clk); #1;
    send8(8'hFF, 8'hFF, 1'b1);
    wait_done8(1'b0, cyc);
    chk("ff_ff_s", 32'(s8), 32'hFF);
    @(posedge clk); #1;
    send8(8'h5A, 8'h3C, 1'b1);
    wait_done8(1'b1, cyc);
    chk("toggle_lat", 32'(cyc), 32'd8);
    chk("toggle_s", 32'(s8), 32'h97);
    chk("toggle_cout", 32'(cout8), 32'd0);
    @(posedge clk); #1;

    out_ready8 = 1'b0;
    send8(8'hC3, 8'h21, 1'b0);
    wait_done8(1'b0, cyc);
    s_hold = s8; c_hold = cout8;
    chk("bp_s", 32'(s8), 32'hE4);
    in_valid8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid8), 32'd1);
      chk("bp_in_ready", 32'(in_ready8), 32'd0);
      chk("bp_s_stable", 32'(s8), 32'(s_hold));
      chk("bp_cout_stable", 32'(cout8), 32'(c_hold));
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready8), 32'd1);
    chk("bp_release_out_valid", 32'(out_valid8), 32'd0);
    @(posedge clk); #1 in_valid8 = 1'b0;
    wait_done8(1'b0, cyc);
    chk("bp_next_lat", 32'(cyc), 32'd8);
    chk("bp_next_s", 32'(s8), 32'h11);
    @(posedge clk); #1;

    send8(8'h33, 8'h44, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready8), 32'd1);
    chk("arst_out_valid", 32'(out_valid8), 32'd0);
    chk("arst_s", 32'(s8), 32'd0);
    chk("arst_cout", 32'(cout8), 32'd0);
    q8.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("arst_no_result", 32'(out_valid8), 32'd0);
    send8(8'h10, 8'h20, 1'b0);
    wait_done8(1'b0, cyc);
    chk("arst_next_s", 32'(s8), 32'h30);
    chk("arst_next_cout", 32'(cout8), 32'd0);
    @(posedge clk); #1;

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          send4(4'(x), 4'(y), 1'(c));
    out_ready4 = 1'b1;
    for (int i = 0; i < 20 && q4.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    chk("drain4", 32'(q4.size()), 32'd0);
    chk("drain8", 32'(q8.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
